// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types for the unified memory-port arbiter.
//   arbstate_t : access sequencer states (IDLE -> ISSUE -> WAIT -> RESP)
//   owner_t    : which requester owns the port (CPU or DMA/boot loader)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arbstate_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2
//   Combinational two-way round-robin pick.
//   req[0] is the CPU, req[1] is the DMA/boot loader. When both request,
//   the one that did not own the port last wins, so neither can be starved.
// Ports:
//   req         in  2  request vector {dma, cpu}
//   last_owner  in  1  owner of the most recent grant
//   grant_valid out 1  at least one requester is asking
//   grant_owner out 1  requester to grant (meaningful when grant_valid)
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_owner,
  output logic       grant_valid,
  output owner_t     grant_owner
);

  always_comb begin
    grant_valid = |req;
    grant_owner = OWN_CPU;
    if (req == 2'b11) begin
      if (last_owner == OWN_CPU) grant_owner = OWN_DMA;
      else                       grant_owner = OWN_CPU;
    end else if (req == 2'b10) begin
      grant_owner = OWN_DMA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one unified instruction/data memory port between the multicycle
//   CPU controller and the DMA/boot loader. Each access is one ISSUE cycle
//   (mem_en high), MEM_LAT WAIT cycles, then one RESP cycle in which the
//   owner's ready pulses and rdata holds the captured read data.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata, cpu_ready  CPU requester (req held until ready)
//   dma_req/we/addr/wdata, dma_ready  DMA requester (req held until ready)
//   rdata                             registered read data, valid with ready
//   mem_en/we/addr/wdata, mem_rdata   memory macro interface
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Counter holds MEM_LAT-1 down to 0, so MEM_LAT=1 gives a 1-bit counter
  // loaded with 0 and a single WAIT cycle.
  localparam int              CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arbstate_t         state;
  owner_t            last_owner;
  owner_t            owner_p0;
  logic              we_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_p1;

  logic              grant_valid;
  owner_t            grant_owner;

  rr_pick2 u_pick (
    .req         ({dma_req, cpu_req}),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // Grant stage: payload is captured here so later requester changes
  // cannot disturb the access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_owner <= OWN_DMA;
      owner_p0   <= OWN_CPU;
      we_p0      <= 1'b0;
      addr_p0    <= '0;
      wdata_p0   <= '0;
      cnt        <= '0;
      rdata_p1   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner_p0   <= grant_owner;
            last_owner <= grant_owner;
            if (grant_owner == OWN_CPU) begin
              we_p0    <= cpu_we;
              addr_p0  <= cpu_addr;
              wdata_p0 <= cpu_wdata;
            end else begin
              we_p0    <= dma_we;
              addr_p0  <= dma_addr;
              wdata_p0 <= dma_wdata;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= CNT_LOAD;
          state <= WAIT;
        end
        // Response stage: read data is sampled on the last WAIT cycle;
        // writes leave the previous rdata visible.
        WAIT: begin
          if (cnt == '0) begin
            if (!we_p0) rdata_p1 <= mem_rdata;
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Memory command is decoded straight from state so mem_en cannot appear
  // outside ISSUE and drops the instant reset is asserted.
  always_comb begin
    mem_en    = (state == ISSUE);
    mem_we    = (state == ISSUE) && we_p0;
    mem_addr  = addr_p0;
    mem_wdata = wdata_p0;
    rdata     = rdata_p1;
    cpu_ready = (state == RESP) && (owner_p0 == OWN_CPU);
    dma_ready = (state == RESP) && (owner_p0 == OWN_DMA);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_ready;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic        dma_ready;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ready(dma_ready),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data appears exactly L cycles after the mem_en cycle;
  // any other slot carries a poison value.
  logic [31:0] mem [0:255];
  logic [31:0] pipe [0:L-1];
  assign mem_rdata = pipe[L-1];

  always @(posedge clk) begin
    for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 32'hBAD0_BAD0;
    if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } issue_t;

  typedef struct {
    int          cyc;
    logic        dma;
    logic [31:0] rdata;
  } resp_t;

  issue_t iq[$];
  resp_t  rq[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push_issue(input int c, input logic we, input logic [31:0] a, input logic [31:0] d);
    issue_t e;
    e.cyc = c; e.we = we; e.addr = a; e.wdata = d;
    iq.push_back(e);
  endtask

  task automatic push_resp(input int c, input logic dma, input logic [31:0] d);
    resp_t e;
    e.cyc = c; e.dma = dma; e.rdata = d;
    rq.push_back(e);
  endtask

  // Monitor: samples on the falling edge, pops expectations whenever the DUT
  // presents a memory command or a ready pulse.
  always @(negedge clk) begin
    if (mem_en) begin
      if (iq.size() == 0) begin
        check("unexpected_mem_en", 1'b1, 1'b0);
      end else begin
        issue_t e;
        e = iq.pop_front();
        check("issue_cycle", 64'(cyc), 64'(e.cyc));
        check("issue_we", mem_we, e.we);
        check("issue_addr", mem_addr, e.addr);
        if (e.we) check("issue_wdata", mem_wdata, e.wdata);
      end
    end
    if (cpu_ready || dma_ready) begin
      check("ready_exclusive", cpu_ready && dma_ready, 1'b0);
      if (rq.size() == 0) begin
        check("unexpected_ready", 1'b1, 1'b0);
      end else begin
        resp_t r;
        r = rq.pop_front();
        check("resp_cycle", 64'(cyc), 64'(r.cyc));
        check("resp_owner_dma", dma_ready, r.dma);
        check("resp_rdata", rdata, r.rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until every raised request has seen its ready; each requester
  // drops req in the ready cycle.
  task automatic serve();
    int n = 0;
    while ((cpu_req || dma_req) && n < 40) begin
      tick();
      n++;
      if (cpu_ready) cpu_req = 1'b0;
      if (dma_ready) dma_req = 1'b0;
    end
    if (cpu_req || dma_req) begin
      check("serve_timeout", 1'b1, 1'b0);
      cpu_req = 1'b0;
      dma_req = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cpu_ready"}, cpu_ready, 1'b0);
    check({tag, "_dma_ready"}, dma_ready, 1'b0);
    check({tag, "_mem_en"}, mem_en, 1'b0);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_rdata"}, rdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < L; i++) pipe[i] = 32'hBAD0_BAD0;
    mem[8'h40] = 32'hDEAD_BEEF;

    repeat (3) tick();
    check_outputs_zero("reset");
    reset_n = 1'b1;
    tick();

    // Single CPU read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    t0 = cyc;
    push_issue(t0 + 1, 1'b0, 32'h40, 32'h0);
    push_resp(t0 + L + 2, 1'b0, 32'hDEAD_BEEF);
    serve();
    tick();

    // DMA write 0x40, then CPU read it back
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h1234_5678;
    t0 = cyc;
    push_issue(t0 + 1, 1'b1, 32'h40, 32'h1234_5678);
    push_resp(t0 + L + 2, 1'b1, 32'hDEAD_BEEF);
    serve();
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    t0 = cyc;
    push_issue(t0 + 1, 1'b0, 32'h40, 32'h0);
    push_resp(t0 + L + 2, 1'b0, 32'h1234_5678);
    serve();
    tick();

    // Tie after reset: CPU first, DMA one access later
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'hCAFE_F00D;
    t0 = cyc;
    push_issue(t0 + 1, 1'b0, 32'h40, 32'h0);
    push_resp(t0 + L + 2, 1'b0, 32'h1234_5678);
    push_issue(t0 + L + 4, 1'b1, 32'h20, 32'hCAFE_F00D);
    push_resp(t0 + 2 * L + 5, 1'b1, 32'h1234_5678);
    serve();
    tick();

    // Next tie (last owner DMA) goes to CPU again
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40;
    t0 = cyc;
    push_issue(t0 + 1, 1'b0, 32'h20, 32'h0);
    push_resp(t0 + L + 2, 1'b0, 32'hCAFE_F00D);
    push_issue(t0 + L + 4, 1'b0, 32'h40, 32'h0);
    push_resp(t0 + 2 * L + 5, 1'b1, 32'h1234_5678);
    serve();
    tick();

    // Payload changed one cycle after grant is ignored
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    t0 = cyc;
    push_issue(t0 + 1, 1'b0, 32'h40, 32'h0);
    push_resp(t0 + L + 2, 1'b0, 32'h1234_5678);
    tick();
    cpu_addr = 32'h80; cpu_we = 1'b1; cpu_wdata = 32'hFFFF_FFFF;
    serve();
    cpu_we = 1'b0;
    tick();

    // DMA abandons its write during WAIT; access still completes
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h10; dma_wdata = 32'hA5;
    t0 = cyc;
    push_issue(t0 + 1, 1'b1, 32'h10, 32'hA5);
    push_resp(t0 + L + 2, 1'b1, 32'h1234_5678);
    repeat (2) tick();
    dma_req = 1'b0;
    repeat (L + 3) tick();
    check("abandon_mem_10", mem[8'h10], 32'hA5);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    t0 = cyc;
    push_issue(t0 + 1, 1'b0, 32'h10, 32'h0);
    push_resp(t0 + L + 2, 1'b0, 32'hA5);
    serve();
    tick();

    // Reset during WAIT: everything clears, held request is re-granted
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    t0 = cyc;
    push_issue(t0 + 1, 1'b0, 32'h40, 32'h0);
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    tick();
    reset_n = 1'b1;
    push_issue(t0 + 4, 1'b0, 32'h40, 32'h0);
    push_resp(t0 + L + 5, 1'b0, 32'h1234_5678);
    serve();
    repeat (4) tick();

    check("issue_queue_drained", 64'(iq.size()), 64'd0);
    check("resp_queue_drained", 64'(rq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
